// File: rtl/hdc_pkg.sv
// hdc_pkg: shared constants and the bundler controller state encoding
// for the sparse HDC encoder.
//   FEATURE_COUNT      : bits in one feature vector from the binder
//   SEQ_BUNDLER_CYCLES : chunk cycles per dimension; sel value that fires threshold
//   ENCODING_BIT_THR   : popcount threshold applied by the bundler
//   DIM                : hypervector dimensions produced per encode
//   bundler_ctrl_state_e : controller FSM states
package hdc_pkg;

  localparam int FEATURE_COUNT      = 40;
  localparam int SEQ_BUNDLER_CYCLES = 10;
  localparam int ENCODING_BIT_THR   = 20;
  localparam int DIM                = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ACCUM   = 3'd2,
    THRESH  = 3'd3,
    CAPTURE = 3'd4,
    OUTPUT  = 3'd5,
    FLUSH   = 3'd6
  } bundler_ctrl_state_e;

endpackage

// File: rtl/bundler_ctrl_chunk_cnt.sv
// bundler_ctrl_chunk_cnt: loadable, enabled up-counter with a terminal-count
// flag. Drives the bundler chunk select while the controller accumulates.
//   clk, nrst   : clock, asynchronous active-low reset
//   load_i      : load load_val_i (wins over en_i)
//   load_val_i  : value to load
//   en_i        : increment by one
//   cnt_o       : current count
//   tc_o        : count equals TC_VAL
module bundler_ctrl_chunk_cnt #(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] TC_VAL = '1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/bundler_ctrl.sv
// bundler_ctrl: sequencer for the sequential bundler datapath. For each
// dimension it fetches the feature vector, steps the bundler select through
// all chunks, fires one threshold cycle, clears the accumulator while
// capturing the thresholded bit, and finally offers the hypervector.
//
// Ports:
//   clk, nrst            : clock, asynchronous active-low reset
//   start                : begin encode (sampled only in IDLE)
//   abort                : synchronous cancel, highest priority
//   busy                 : high outside IDLE
//   feat_req/feat_addr   : feature vector request for one dimension
//   feat_ack             : source has driven the requested vector
//   bnd_en, bnd_start_bundling, bnd_sel : bundler controls
//   bnd_thresholded_bit  : bundler registered threshold output
//   hv_out/hv_valid/hv_ready : hypervector output handshake
//   dbg_state            : current FSM state (bundler_ctrl_state_e encoding)
//   perf_cycles/perf_stall : only when BUNDLER_CTRL_PERF_EN is defined
//
// Optional feature macro: BUNDLER_CTRL_PERF_EN adds the perf counters.
//
// Handshake: hv_valid rises with the full hypervector and stays high with
// hv_out stable until a cycle where hv_ready is high; that edge returns to
// IDLE and hv_valid drops. valid never depends on ready in the same cycle.
// All outputs decode registered state only.
module bundler_ctrl #(
  parameter int DIM                = hdc_pkg::DIM,
  parameter int SEQ_BUNDLER_CYCLES = hdc_pkg::SEQ_BUNDLER_CYCLES,
  parameter int SEL_W              = 4,
  parameter int IDX_W              = $clog2(DIM)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             feat_req,
  output logic [IDX_W-1:0] feat_addr,
  input  logic             feat_ack,
  output logic             bnd_en,
  output logic             bnd_start_bundling,
  output logic [SEL_W-1:0] bnd_sel,
  input  logic             bnd_thresholded_bit,
  output logic [DIM-1:0]   hv_out,
  output logic             hv_valid,
  input  logic             hv_ready,
  output logic [2:0]       dbg_state
`ifdef BUNDLER_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stall
`endif
);

  import hdc_pkg::*;

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_FETCH   = FETCH;
  localparam logic [2:0] S_ACCUM   = ACCUM;
  localparam logic [2:0] S_THRESH  = THRESH;
  localparam logic [2:0] S_CAPTURE = CAPTURE;
  localparam logic [2:0] S_OUTPUT  = OUTPUT;
  localparam logic [2:0] S_FLUSH   = FLUSH;

  localparam logic [SEL_W-1:0] SEL_THR  = SEL_W'(SEQ_BUNDLER_CYCLES);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SEQ_BUNDLER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] dim_idx_q, dim_idx_d;
  logic [DIM-1:0]   hv_q, hv_d;
  logic             cnt_load;
  logic             cnt_en;
  logic [SEL_W-1:0] cnt_val;
  logic             cnt_tc;
  logic             start_acc;

  bundler_ctrl_chunk_cnt #(
    .WIDTH  (SEL_W),
    .TC_VAL (SEL_LAST)
  ) u_chunk_cnt (
    .clk        (clk),
    .nrst       (nrst),
    .load_i     (cnt_load),
    .load_val_i ('0),
    .en_i       (cnt_en),
    .cnt_o      (cnt_val),
    .tc_o       (cnt_tc)
  );

  assign start_acc = (state_q == S_IDLE) && start;

  always_comb begin
    state_d   = state_q;
    dim_idx_d = dim_idx_q;
    hv_d      = hv_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    // Abort beats every other event; FLUSH then clears the bundler accumulator.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_FLUSH;
      hv_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_FETCH;
            dim_idx_d = '0;
            hv_d      = '0;
          end
        end
        S_FETCH: begin
          if (feat_ack) begin
            cnt_load = 1'b1;
            state_d  = S_ACCUM;
          end
        end
        S_ACCUM: begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = S_THRESH;
          end
        end
        S_THRESH: begin
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          // Bundler latched its threshold at the THRESH edge, so it is valid now.
          hv_d[dim_idx_q] = bnd_thresholded_bit;
          if (dim_idx_q == IDX_LAST) begin
            state_d = S_OUTPUT;
          end else begin
            dim_idx_d = dim_idx_q + IDX_W'(1);
            state_d   = S_FETCH;
          end
        end
        S_OUTPUT: begin
          if (hv_ready) begin
            state_d = S_IDLE;
          end
        end
        S_FLUSH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      dim_idx_q <= '0;
      hv_q      <= '0;
    end else begin
      state_q   <= state_d;
      dim_idx_q <= dim_idx_d;
      hv_q      <= hv_d;
    end
  end

  assign busy               = (state_q != S_IDLE);
  assign feat_req           = (state_q == S_FETCH);
  assign feat_addr          = (state_q == S_FETCH) ? dim_idx_q : '0;
  assign bnd_en             = (state_q == S_ACCUM) || (state_q == S_THRESH) ||
                              (state_q == S_CAPTURE) || (state_q == S_FLUSH);
  assign bnd_start_bundling = (state_q == S_ACCUM) || (state_q == S_THRESH);
  // The threshold select value appears only in THRESH, so the bundler never
  // latches a stray threshold.
  assign bnd_sel            = (state_q == S_ACCUM)  ? cnt_val :
                              (state_q == S_THRESH) ? SEL_THR : '0;
  assign hv_valid           = (state_q == S_OUTPUT);
  assign hv_out             = (state_q == S_OUTPUT) ? hv_q : '0;
  assign dbg_state          = state_q;

`ifdef BUNDLER_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_stall_q;
  logic        working;

  assign working = (state_q == S_FETCH) || (state_q == S_ACCUM) ||
                   (state_q == S_THRESH) || (state_q == S_CAPTURE);

  // Counters only advance in working states, so they freeze in OUTPUT and
  // hold after FLUSH until the next accepted start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (start_acc) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (working && !(&perf_cycles_q)) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if ((state_q == S_FETCH) && !feat_ack && !(&perf_stall_q)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_bundler_ctrl.sv
// tb_bundler_ctrl: directed bench for bundler_ctrl at DIM=8. Contains a
// feature source that answers feat_req (with optional stall on one
// dimension) and a behavioural bundler that sums 4-bit chunk popcounts and
// thresholds at >= 20.
module tb_bundler_ctrl;

  localparam int DIM   = 8;
  localparam int SEQ   = 10;
  localparam int SEL_W = 4;
  localparam int IDX_W = 3;
  localparam int FW    = 40;
  localparam int THR   = 20;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic             start    = 1'b0;
  logic             abort    = 1'b0;
  logic             feat_ack = 1'b0;
  logic             hv_ready = 1'b0;
  logic             bnd_thresholded_bit;
  logic             busy, feat_req, bnd_en, bnd_start_bundling, hv_valid;
  logic [IDX_W-1:0] feat_addr;
  logic [SEL_W-1:0] bnd_sel;
  logic [DIM-1:0]   hv_out;
  logic [2:0]       dbg_state;
`ifdef BUNDLER_CTRL_PERF_EN
  logic [31:0]      perf_cycles, perf_stall;
`endif

  bundler_ctrl #(
    .DIM                (DIM),
    .SEQ_BUNDLER_CYCLES (SEQ),
    .SEL_W              (SEL_W),
    .IDX_W              (IDX_W)
  ) dut (
    .clk                 (clk),
    .nrst                (nrst),
    .start               (start),
    .abort               (abort),
    .busy                (busy),
    .feat_req            (feat_req),
    .feat_addr           (feat_addr),
    .feat_ack            (feat_ack),
    .bnd_en              (bnd_en),
    .bnd_start_bundling  (bnd_start_bundling),
    .bnd_sel             (bnd_sel),
    .bnd_thresholded_bit (bnd_thresholded_bit),
    .hv_out              (hv_out),
    .hv_valid            (hv_valid),
    .hv_ready            (hv_ready),
    .dbg_state           (dbg_state)
`ifdef BUNDLER_CTRL_PERF_EN
    ,
    .perf_cycles         (perf_cycles),
    .perf_stall          (perf_stall)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- feature source ----------------
  logic [FW-1:0] feat_pat [DIM];
  logic [FW-1:0] feat_bits = '0;
  int stall_dim = -1;
  int stall_len = 0;

  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (feat_req && !feat_ack) begin
        if ((int'(feat_addr) == stall_dim) && (wait_cnt < stall_len)) begin
          wait_cnt++;
        end else begin
          feat_bits = feat_pat[feat_addr];
          feat_ack  = 1'b1;
          wait_cnt  = 0;
        end
      end else begin
        feat_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // ---------------- bundler model ----------------
  logic [7:0] acc_m;
  logic       thr_m;
  assign bnd_thresholded_bit = thr_m;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_m <= '0;
      thr_m <= 1'b0;
    end else if (bnd_en) begin
      if (bnd_start_bundling) begin
        if (int'(bnd_sel) < SEQ) begin
          acc_m <= acc_m + 8'($countones(feat_bits[int'(bnd_sel)*4 +: 4]));
        end
        if (int'(bnd_sel) == SEQ) begin
          thr_m <= (int'(acc_m) >= THR);
        end
      end else begin
        acc_m <= '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_pattern(input logic [DIM-1:0] hv);
    for (int d = 0; d < DIM; d++) begin
      feat_pat[d] = hv[d] ? {FW{1'b1}} : {FW{1'b0}};
    end
  endtask

  // Returns at the negedge of the first encode cycle (first FETCH cycle).
  task automatic start_encode();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [11:0] exp_trace(input int c);
    int p;
    int d;
    p = c % 13;
    d = c / 13;
    if (p == 0)       exp_trace = {1'b1, 1'b1, 3'(d), 1'b0, 1'b0, 4'd0, 1'b0};
    else if (p <= 10) exp_trace = {1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 4'(p - 1), 1'b0};
    else if (p == 11) exp_trace = {1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 4'd10, 1'b0};
    else              exp_trace = {1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 4'd0, 1'b0};
  endfunction

  // Checks every cycle of a zero-wait encode; ends in the first OUTPUT cycle.
  task automatic trace_encode();
    for (int c = 0; c < DIM * 13; c++) begin
      check($sformatf("trace_c%0d", c),
            {busy, feat_req, (feat_req ? feat_addr : 3'd0), bnd_en,
             bnd_start_bundling, bnd_sel, hv_valid},
            exp_trace(c));
      if ((c % 13) == 0) check($sformatf("acc_zero_fetch_c%0d", c), acc_m, 8'd0);
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!hv_valid && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check("hv_valid_timeout", hv_valid, 1'b1);
  endtask

  task automatic finish_output();
    hv_ready = 1'b1;
    @(negedge clk);
    hv_ready = 1'b0;
    check("done_busy", busy, 1'b0);
    check("done_valid", hv_valid, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {busy, feat_req, feat_addr, bnd_en, bnd_start_bundling, bnd_sel, hv_valid, hv_out, dbg_state},
          23'd0);
    nrst = 1'b1;
    @(negedge clk);

    // 1: all ones, cycle-exact trace, 104-cycle latency
    load_pattern(8'hFF);
    start_encode();
    trace_encode();
    check("t1_valid", hv_valid, 1'b1);
    check("t1_hv", hv_out, 8'hFF);
`ifdef BUNDLER_CTRL_PERF_EN
    check("t1_perf_cycles", perf_cycles, 32'd104);
    check("t1_perf_stall", perf_stall, 32'd0);
`endif
    finish_output();

    // 2: alternating dimensions
    load_pattern(8'h55);
    start_encode();
    trace_encode();
    check("t2_hv", hv_out, 8'h55);
    finish_output();

    // 3: 3-cycle ack delay on dimension 2
    load_pattern(8'hDF);
    stall_dim = 2;
    stall_len = 3;
    start_encode();
    begin
      int lat, req2, en_viol;
      lat = 0; req2 = 0; en_viol = 0;
      while (!hv_valid && (lat < 300)) begin
        if (feat_req && (feat_addr == 3'd2)) req2++;
        if (feat_req && bnd_en) en_viol++;
        @(negedge clk);
        lat++;
      end
      check("t3_latency", lat, 107);
      check("t3_req2_cycles", req2, 4);
      check("t3_en_in_fetch", en_viol, 0);
    end
    check("t3_hv", hv_out, 8'hDF);
`ifdef BUNDLER_CTRL_PERF_EN
    check("t3_perf_stall", perf_stall, 32'd3);
    check("t3_perf_cycles", perf_cycles, 32'd107);
`endif
    stall_dim = -1;
    finish_output();

    // 4: abort in ACCUM of dimension 3 at sel=5
    load_pattern(8'hFF);
    start_encode();
    repeat (45) @(negedge clk);
    check("t4_sel_before_abort", {bnd_en, bnd_start_bundling, bnd_sel}, {1'b1, 1'b1, 4'd5});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_flush", {busy, bnd_en, bnd_start_bundling, bnd_sel, hv_valid},
          {1'b1, 1'b1, 1'b0, 4'd0, 1'b0});
    @(negedge clk);
    check("t4_idle", {busy, bnd_en, hv_valid}, 3'b000);
    check("t4_acc_cleared", acc_m, 8'd0);
`ifdef BUNDLER_CTRL_PERF_EN
    repeat (2) @(negedge clk);
    check("t4_perf_hold", perf_cycles, 32'd46);
`endif
    // abort coinciding with feat_ack: abort wins
    start_encode();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_abort_vs_ack", {busy, bnd_en, bnd_start_bundling}, 3'b110);
    @(negedge clk);
    check("t4_abort_vs_ack_idle", busy, 1'b0);
    load_pattern(8'hA5);
    start_encode();
    trace_encode();
    check("t4_next_hv", hv_out, 8'hA5);
    finish_output();

    // 5: backpressure with start pulses ignored
    load_pattern(8'h3C);
    start_encode();
    wait_valid(200);
    for (int i = 0; i < 20; i++) begin
      start = ((i % 4) == 0);
      check($sformatf("t5_valid_%0d", i), hv_valid, 1'b1);
      check($sformatf("t5_hv_%0d", i), hv_out, 8'h3C);
      @(negedge clk);
    end
    start = 1'b0;
`ifdef BUNDLER_CTRL_PERF_EN
    check("t5_perf_frozen", perf_cycles, 32'd104);
`endif
    hv_ready = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    hv_ready = 1'b0;
    start    = 1'b0;
    check("t5_ready_start_busy", busy, 1'b0);
    check("t5_ready_start_valid", hv_valid, 1'b0);
    @(negedge clk);
    check("t5_start_not_taken", busy, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort_idle", {busy, bnd_en}, 2'b00);

    // 6: asynchronous reset during THRESH
    load_pattern(8'hFF);
    start_encode();
    repeat (11) @(negedge clk);
    check("t6_in_thresh", bnd_sel, 4'd10);
    nrst = 1'b0;
    #1;
    check("t6_async_reset",
          {busy, feat_req, feat_addr, bnd_en, bnd_start_bundling, bnd_sel, hv_valid, hv_out, dbg_state},
          23'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    load_pattern(8'h55);
    start_encode();
    trace_encode();
    check("t6_hv", hv_out, 8'h55);
    finish_output();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bundler_ctrl.md
Name: bundler_ctrl

Overview:
Sequencer for the sequential bundler datapath in the sparse HDC encoder. For each hypervector dimension it fetches the feature bit vector from the upstream binder, then steps the bundler mux select through all chunks. It fires the threshold cycle, clears the accumulator, and captures the thresholded bit. After all DIM bits are collected, it presents the full hypervector on a valid/ready output.

Parameters:
DIM, 64, hypervector dimensions produced per encode
SEQ_BUNDLER_CYCLES, 10, chunk cycles per dimension; sel value that triggers thresholding
SEL_W, 4, bundler select width; must satisfy 2**SEL_W > SEQ_BUNDLER_CYCLES
IDX_W, $clog2(DIM), dimension index width

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
start  in  1  begin encode; sampled only in IDLE
abort  in  1  synchronous cancel; highest priority
busy  out  1  high in every state except IDLE
feat_req  out  1  request feature vector for feat_addr
feat_addr  out  IDX_W  dimension index being requested
feat_ack  in  1  source has driven bits_to_bundle for feat_addr; holds it until next feat_req
bnd_en  out  1  bundler enable
bnd_start_bundling  out  1  bundler accumulate (1) / clear (0)
bnd_sel  out  SEL_W  bundler chunk select
bnd_thresholded_bit  in  1  bundler registered output
hv_out  out  DIM  encoded hypervector, bit d = dimension d
hv_valid  out  1  hv_out valid
hv_ready  in  1  downstream accepts hv_out

Behaviour:
- Reset values: all outputs 0; state IDLE; dim_idx 0; hv register 0.
- Interface rule: clk and nrst (asynchronous, active-low) as listed. All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- FSM states and outputs:
  - IDLE: en=0, sel=0. On start, clear dim_idx and move to FETCH.
  - FETCH: feat_req=1, feat_addr=dim_idx, en=0. On feat_ack, clear chunk counter and move to ACCUM.
  - ACCUM: en=1, start_bundling=1, sel=chunk counter (0..SEQ_BUNDLER_CYCLES-1). The counter increments each cycle. Move to THRESH after sel=SEQ_BUNDLER_CYCLES-1.
  - THRESH: en=1, start_bundling=1, sel=SEQ_BUNDLER_CYCLES, for one cycle. The bundler adds 0 (default mux) and latches its threshold at this edge. Move to CAPTURE.
  - CAPTURE: en=1, start_bundling=0, sel=0. The bundler accumulator clears. At this edge, hv[dim_idx] <= bnd_thresholded_bit.
    - If dim_idx==DIM-1, go to OUTPUT.
    - Else dim_idx+1, go to FETCH.
  - OUTPUT: hv_valid=1, hv_out stable. On hv_ready, go to IDLE, hv_valid drops the next cycle.
  - FLUSH: en=1, start_bundling=0, sel=0, for one cycle, then IDLE.
- sel equals SEQ_BUNDLER_CYCLES only in THRESH. No spurious threshold updates occur.
- Per-dimension latency with zero-wait ack: 1 FETCH + SEQ_BUNDLER_CYCLES + 1 + 1 cycles (13 at defaults).
- The bits_to_bundle source holds its value from feat_ack through CAPTURE. The controller does not re-check this.
- Boundary conditions:
  - start while busy: ignored.
  - abort in any non-IDLE state: go to FLUSH, so the bundler accumulator ends at zero. hv_valid drops the next cycle and hv register contents are discarded.
  - abort together with feat_ack or hv_ready: abort wins.
  - abort in IDLE: no effect.
  - start and hv_ready in the same OUTPUT cycle: go to IDLE only. The new start must be reasserted.
  - feat_ack outside FETCH: ignored.
  - dim_idx does not wrap; it terminates at DIM-1.
  - Reset mid-encode: immediate IDLE, all outputs 0. The bundler shares nrst and clears too.

Optional Feature:
BUNDLER_CTRL_PERF_EN
- Defined: adds output perf_cycles[31:0] and output perf_stall[31:0].
  - perf_cycles counts cycles in FETCH/ACCUM/THRESH/CAPTURE of the current encode.
  - perf_stall counts FETCH cycles with feat_ack=0.
  - Both clear on start acceptance, freeze in OUTPUT, hold after abort, and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hdc_pkg holds FEATURE_COUNT, SEQ_BUNDLER_CYCLES, ENCODING_BIT_THR, DIM, and the bundler_ctrl_state_e enum (IDLE, FETCH, ACCUM, THRESH, CAPTURE, OUTPUT, FLUSH).
- One sub-module is natural: bundler_ctrl_chunk_cnt. It is a loadable, enabled up-counter with a terminal-count flag.

Test Plan:
1. DIM=8, zero-wait ack, all feature vectors 40'hFF_FFFF_FFFF -> hv_out=8'hFF; hv_valid rises 104 cycles after start accept; bnd_sel sequence 0..9,10,0 per dimension.
2. Alternating dimensions: all-ones for even, all-zeros for odd -> hv_out=8'h55. The bundler accumulator reads 0 at each FETCH.
3. feat_ack delayed 3 cycles on dimension 2 -> feat_req/feat_addr=2 held for 4 cycles, en=0 during the wait, hv result unchanged. With BUNDLER_CTRL_PERF_EN: perf_stall=3, perf_cycles=107.
4. abort during ACCUM of dimension 3 at sel=5 -> one FLUSH cycle (en=1, start_bundling=0), then IDLE. busy=0 and hv_valid never asserted. The next encode produces correct results.
5. hv_ready held low 20 cycles in OUTPUT -> hv_out stable, hv_valid=1, start pulses ignored. After hv_ready=1, IDLE next cycle.
6. nrst asserted mid-THRESH -> all outputs 0 asynchronously. After release, a fresh start completes normally.
